// File: rtl/imm_ext_pkg.sv
// Immediate-extension mode encodings, shared by the extension stage and the control decoder.
package imm_ext_pkg;

  typedef logic [1:0] ext_mode_t;

  localparam ext_mode_t EXT_ZERO = 2'b00;
  localparam ext_mode_t EXT_SIGN = 2'b01;
  localparam ext_mode_t EXT_LUI  = 2'b10;
  localparam ext_mode_t EXT_BR   = 2'b11;

endpackage : imm_ext_pkg

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: zero, sign, upper-load and branch-offset forms.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  ext_mode_t        mode,
  output logic [OUT_W-1:0] ext
);

  localparam int unsigned PAD_W = OUT_W - IN_W;

  logic [OUT_W-1:0] zero_ext;
  logic [OUT_W-1:0] sign_ext;

  assign zero_ext = {{PAD_W{1'b0}}, imm};
  assign sign_ext = {{PAD_W{imm[IN_W-1]}}, imm};

  always_comb begin
    ext = zero_ext;
    unique case (mode)
      EXT_ZERO: ext = zero_ext;
      EXT_SIGN: ext = sign_ext;
      EXT_LUI:  ext = {imm, {PAD_W{1'b0}}};
      EXT_BR:   ext = {sign_ext[OUT_W-3:0], 2'b00};
      default:  ext = zero_ext;
    endcase
  end

endmodule : imm_ext_core

// File: rtl/imm_ext_stage.sv
// Pipelined immediate-extension stage: extender feeding a main/skid two-entry buffer
// with registered ready and synchronous flush.
module imm_ext_stage
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  ext_mode_t        in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  logic [OUT_W-1:0] ext_c;
  logic             in_xfer_c;
  logic             out_xfer_c;

  // Main entry is the output register itself (out_valid/out_data/out_tag).
  logic             skid_valid;
  logic [OUT_W-1:0] skid_data;
  logic [TAG_W-1:0] skid_tag;

  logic             main_valid_n;
  logic [OUT_W-1:0] main_data_n;
  logic [TAG_W-1:0] main_tag_n;
  logic             skid_valid_n;
  logic [OUT_W-1:0] skid_data_n;
  logic [TAG_W-1:0] skid_tag_n;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm  (in_imm),
    .mode (in_mode),
    .ext  (ext_c)
  );

  assign in_xfer_c  = in_valid && in_ready;
  assign out_xfer_c = out_valid && out_ready;

  // Next-state of both entries; skid always refills main first so order stays FIFO.
  always_comb begin
    main_valid_n = out_valid;
    main_data_n  = out_data;
    main_tag_n   = out_tag;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    skid_tag_n   = skid_tag;

    if (flush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else if (!out_valid || out_xfer_c) begin
      if (skid_valid) begin
        main_valid_n = 1'b1;
        main_data_n  = skid_data;
        main_tag_n   = skid_tag;
        skid_valid_n = in_xfer_c;
        if (in_xfer_c) begin
          skid_data_n = ext_c;
          skid_tag_n  = in_tag;
        end
      end else begin
        main_valid_n = in_xfer_c;
        if (in_xfer_c) begin
          main_data_n = ext_c;
          main_tag_n  = in_tag;
        end
      end
    end else if (in_xfer_c) begin
      skid_valid_n = 1'b1;
      skid_data_n  = ext_c;
      skid_tag_n   = in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_tag    <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_tag   <= '0;
      in_ready   <= 1'b1;
    end else begin
      out_valid  <= main_valid_n;
      out_data   <= main_data_n;
      out_tag    <= main_tag_n;
      skid_valid <= skid_valid_n;
      skid_data  <= skid_data_n;
      skid_tag   <= skid_tag_n;
      in_ready   <= !skid_valid_n;
    end
  end

endmodule : imm_ext_stage

// File: tb/tb_imm_ext_stage.sv
// Self-checking bench for imm_ext_stage: directed scenarios plus a randomized scoreboard run.
module tb_imm_ext_stage;

  localparam int unsigned IN_W  = 16;
  localparam int unsigned OUT_W = 32;
  localparam int unsigned TAG_W = 5;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  int n_cmp = 0;
  int n_bad = 0;

  imm_ext_stage #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference extension computed with plain integer arithmetic modulo 2^32.
  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
    longint unsigned v;
    longint signed   s;
    v = 64'(imm);
    s = (v >= 64'd32768) ? longint'(v) - 64'sd65536 : longint'(v);
    case (mode)
      2'd0:    return 32'(v);
      2'd1:    return 32'(s);
      2'd2:    return 32'(v * 64'd65536);
      default: return 32'(s * 64'sd4);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_imm   = '0;
    in_mode  = 2'd0;
    in_tag   = '0;
    flush    = 1'b0;
  endtask

  task automatic offer(input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag);
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    in_tag   = tag;
  endtask

  task automatic test_reset();
    idle_inputs();
    out_ready = 1'b1;
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ((out_valid !== 1'b0) || (in_ready !== 1'b1) || (out_data !== 32'h0) || (out_tag !== 5'h0)) begin
      n_bad++;
      $display("FAIL reset_state: got v=%b r=%b d=%h t=%h, want v=0 r=1 d=0 t=0",
               out_valid, in_ready, out_data, out_tag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_modes();
    logic [31:0] want [4];
    want[0] = 32'h00008001;
    want[1] = 32'hFFFF8001;
    want[2] = 32'h80010000;
    want[3] = 32'hFFFE0004;
    out_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      offer(16'h8001, 2'(m), 5'(10 + m));
      step();
      n_cmp++;
      if ((out_valid !== 1'b1) || (out_data !== want[m]) || (out_tag !== 5'(10 + m))) begin
        n_bad++;
        $display("FAIL mode_%0d: got v=%b d=%h t=%0d, want v=1 d=%h t=%0d",
                 m, out_valid, out_data, out_tag, want[m], 10 + m);
      end
    end
    idle_inputs();
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL modes_drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    offer(16'h0001, 2'd0, 5'd1);
    step();
    offer(16'h0002, 2'd0, 5'd2);
    step();
    n_cmp++;
    if ((in_ready !== 1'b0) || (out_valid !== 1'b1) || (out_tag !== 5'd1)) begin
      n_bad++;
      $display("FAIL stall_full: got r=%b v=%b t=%0d, want r=0 v=1 t=1", in_ready, out_valid, out_tag);
    end
    offer(16'h0003, 2'd0, 5'd3);
    step();
    n_cmp++;
    if ((in_ready !== 1'b0) || (out_tag !== 5'd1) || (out_data !== 32'h1)) begin
      n_bad++;
      $display("FAIL stall_hold: got r=%b t=%0d d=%h, want r=0 t=1 d=1", in_ready, out_tag, out_data);
    end
    out_ready = 1'b1;
    step();
    n_cmp++;
    if ((out_valid !== 1'b1) || (out_tag !== 5'd2) || (in_ready !== 1'b1)) begin
      n_bad++;
      $display("FAIL stall_rel2: got v=%b t=%0d r=%b, want v=1 t=2 r=1", out_valid, out_tag, in_ready);
    end
    step();
    idle_inputs();
    n_cmp++;
    if ((out_valid !== 1'b1) || (out_tag !== 5'd3) || (out_data !== 32'h3)) begin
      n_bad++;
      $display("FAIL stall_rel3: got v=%b t=%0d d=%h, want v=1 t=3 d=3", out_valid, out_tag, out_data);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_empty: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0;
    offer(16'h0004, 2'd1, 5'd4);
    step();
    offer(16'h8005, 2'd1, 5'd5);
    step();
    out_ready = 1'b1;
    offer(16'h0006, 2'd3, 5'd6);
    step();
    n_cmp++;
    if ((out_tag !== 5'd5) || (out_data !== 32'hFFFF8005) || (in_ready !== 1'b1)) begin
      n_bad++;
      $display("FAIL simul_skid2main: got t=%0d d=%h r=%b, want t=5 d=ffff8005 r=1",
               out_tag, out_data, in_ready);
    end
    step();
    idle_inputs();
    n_cmp++;
    if ((out_valid !== 1'b1) || (out_tag !== 5'd6) || (out_data !== 32'h00000018)) begin
      n_bad++;
      $display("FAIL simul_next: got v=%b t=%0d d=%h, want v=1 t=6 d=00000018", out_valid, out_tag, out_data);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL simul_empty: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    int seen;
    out_ready = 1'b0;
    offer(16'h0007, 2'd0, 5'd7);
    step();
    offer(16'h0008, 2'd0, 5'd8);
    step();
    offer(16'h0009, 2'd0, 5'd9);
    flush = 1'b1;
    step();
    n_cmp++;
    if ((out_valid !== 1'b0) || (in_ready !== 1'b1)) begin
      n_bad++;
      $display("FAIL flush_clear: got v=%b r=%b, want v=0 r=1", out_valid, in_ready);
    end
    idle_inputs();
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (out_valid === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL flush_leak: got %0d valid cycles after flush, want 0", seen);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    offer(16'h1234, 2'd1, 5'd11);
    step();
    offer(16'h5678, 2'd1, 5'd12);
    step();
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ((out_valid !== 1'b0) || (out_data !== 32'h0) || (in_ready !== 1'b1)) begin
      n_bad++;
      $display("FAIL async_reset: got v=%b d=%h r=%b, want v=0 d=0 r=1", out_valid, out_data, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    offer(16'hFFFF, 2'd2, 5'd13);
    step();
    idle_inputs();
    n_cmp++;
    if ((out_valid !== 1'b1) || (out_data !== 32'hFFFF0000) || (out_tag !== 5'd13)) begin
      n_bad++;
      $display("FAIL post_reset: got v=%b d=%h t=%0d, want v=1 d=ffff0000 t=13", out_valid, out_data, out_tag);
    end
    step();
  endtask

  task automatic test_random();
    logic [36:0]  exp_q[$];
    logic [36:0]  head;
    int           sent;
    int           rcvd;
    int           cycles;
    logic         prev_stall;
    logic [31:0]  prev_data;
    logic [4:0]   prev_tag;
    sent = 0;
    rcvd = 0;
    cycles = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_tag = '0;
    idle_inputs();
    while ((rcvd < 10000) && (cycles < 60000)) begin
      in_valid  = (sent < 10000) && ($urandom_range(0, 99) < 70);
      in_imm    = 16'($urandom);
      in_mode   = 2'($urandom);
      in_tag    = 5'($urandom);
      out_ready = ($urandom_range(0, 99) < 65);
      if (prev_stall) begin
        n_cmp++;
        if ((out_valid !== 1'b1) || (out_data !== prev_data) || (out_tag !== prev_tag)) begin
          n_bad++;
          $display("FAIL rand_stable: got v=%b d=%h t=%0d, want v=1 d=%h t=%0d",
                   out_valid, out_data, out_tag, prev_data, prev_tag);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL rand_extra: got d=%h t=%0d, want no output", out_data, out_tag);
        end else begin
          head = exp_q.pop_front();
          if ({out_tag, out_data} !== head) begin
            n_bad++;
            $display("FAIL rand_item_%0d: got d=%h t=%0d, want d=%h t=%0d",
                     rcvd, out_data, out_tag, head[31:0], head[36:32]);
          end
        end
        rcvd++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({in_tag, ref_ext(in_imm, in_mode)});
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_tag   = out_tag;
      step();
      cycles++;
    end
    idle_inputs();
    n_cmp++;
    if ((rcvd != 10000) || (exp_q.size() != 0)) begin
      n_bad++;
      $display("FAIL rand_count: got rcvd=%0d pending=%0d, want rcvd=10000 pending=0", rcvd, exp_q.size());
    end
  endtask

  initial begin
    idle_inputs();
    out_ready = 1'b1;
    rst_n = 1'b1;
    test_reset();
    test_modes();
    test_stall();
    test_simultaneous();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_imm_ext_stage
